layer_rom_arbiter: RTL and testbench

- Shares one SDRAM tile-ROM read channel between NUM_REQ background-layer fetchers.
- Each layer issues a single-cycle fetch pulse with a 21-bit word address; the arbiter holds it as a one-deep pending slot, grants round-robin, and issues the request to the SDRAM port.
- When the SDRAM returns data, the arbiter sends that data back to the granted layer with a one-cycle ready pulse.
- Sits between the layer blocks and the SDRAM controller's layer-ROM channel.

---
 rtl/layer_rom_arbiter_if.sv | 24 ++
 rtl/layer_rom_arbiter.sv | 169 ++++++++++++++++
 tb/tb_layer_rom_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_rom_arbiter_if.sv
// SDRAM layer-ROM read channel: one request/address pair out, one data-valid pulse back.
interface layer_rom_arbiter_if #(
  parameter int AW = 21,
  parameter int DW = 32
);
  logic          sdr_req;
  logic [AW-1:0] sdr_addr;
  logic          sdr_rdy;
  logic [DW-1:0] sdr_data;

  modport master (
    output sdr_req,
    output sdr_addr,
    input  sdr_rdy,
    input  sdr_data
  );

  modport slave (
    input  sdr_req,
    input  sdr_addr,
    output sdr_rdy,
    output sdr_data
  );
endinterface

// File: rtl/layer_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM tile-ROM read channel between NUM_REQ layer fetchers.
// Each layer owns a one-deep pending slot; the latest address written to a slot wins.
module layer_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 21,
  parameter int DW      = 32
) (
  input  logic                  CLK_32M,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_en,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    rdy,
  output logic [NUM_REQ*DW-1:0] rdata,
  output logic                  busy,
  layer_rom_arbiter_if.master   sdr
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t              state_reg, state_next;
  logic [GW-1:0]       grant_reg, grant_next;
  logic [GW-1:0]       last_grant_reg, last_grant_next;
  logic                sdr_req_reg, sdr_req_next;
  logic [AW-1:0]       sdr_addr_reg, sdr_addr_next;
  logic [NUM_REQ-1:0]  rdy_reg, rdy_next;

  logic [NUM_REQ-1:0]  pend_vec;
  logic [AW-1:0]       addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  done_clr;
  logic [NUM_REQ-1:0]  rdata_we;

  logic                found_hi, found_lo;
  logic [GW-1:0]       pick_hi, pick_lo, pick;
  logic [AW-1:0]       pick_addr;

  assign eligible = pend_vec & req_en;

  // Per-layer pending slot, address latch and returned-data register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      logic          slot_pend_reg;
      logic [AW-1:0] slot_addr_reg;
      logic [DW-1:0] slot_rdata_reg;

      always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
          slot_pend_reg  <= 1'b0;
          slot_addr_reg  <= '0;
          slot_rdata_reg <= '0;
        end else begin
          // A fresh request beats the completion clear in the same cycle.
          if (!req_en[gi]) begin
            slot_pend_reg <= 1'b0;
          end else if (req[gi]) begin
            slot_pend_reg <= 1'b1;
            slot_addr_reg <= req_addr[gi*AW +: AW];
          end else if (done_clr[gi]) begin
            slot_pend_reg <= 1'b0;
          end
          if (rdata_we[gi]) begin
            slot_rdata_reg <= sdr.sdr_data;
          end
        end
      end

      assign pend_vec[gi]           = slot_pend_reg;
      assign addr_arr[gi]           = slot_addr_reg;
      assign rdata[gi*DW +: DW]     = slot_rdata_reg;
    end
  endgenerate

  // Round-robin pick: first eligible index above last_grant, else lowest eligible.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i] && !found_hi && (GW'(i) > last_grant_reg)) begin
        found_hi = 1'b1;
        pick_hi  = GW'(i);
      end
      if (eligible[i] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = GW'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        pick_addr = addr_arr[i];
      end
    end
  end

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      sdr_req_reg    <= 1'b0;
      sdr_addr_reg   <= '0;
      rdy_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      sdr_req_reg    <= sdr_req_next;
      sdr_addr_reg   <= sdr_addr_next;
      rdy_reg        <= rdy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    sdr_req_next    = 1'b0;
    sdr_addr_next   = sdr_addr_reg;
    rdy_next        = '0;
    done_clr        = '0;
    rdata_we        = '0;
    case (state_reg)
      IDLE: begin
        if (found_lo) begin
          grant_next      = pick;
          last_grant_next = pick;
          sdr_addr_next   = pick_addr;
          sdr_req_next    = 1'b1;
          state_next      = WAIT;
        end
      end
      WAIT: begin
        if (sdr.sdr_rdy) begin
          state_next = IDLE;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_reg == GW'(i)) begin
              done_clr[i] = 1'b1;
              // A layer disabled mid-fetch gets neither data nor a pulse.
              if (req_en[i]) begin
                rdy_next[i] = 1'b1;
                rdata_we[i] = 1'b1;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rdy          = rdy_reg;
  assign busy         = (state_reg == WAIT);
  assign sdr.sdr_req  = sdr_req_reg;
  assign sdr.sdr_addr = sdr_addr_reg;

endmodule

// File: tb/tb_layer_rom_arbiter.sv
// Directed bench for layer_rom_arbiter with hand-computed grant order, addresses and data.
module tb_layer_rom_arbiter;
  localparam int NUM_REQ = 3;
  localparam int AW      = 21;
  localparam int DW      = 32;

  logic                  CLK_32M = 1'b0;
  logic                  reset   = 1'b1;
  logic [NUM_REQ-1:0]    req_en  = '1;
  logic [NUM_REQ-1:0]    req     = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]    rdy;
  logic [NUM_REQ*DW-1:0] rdata;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  layer_rom_arbiter_if #(.AW(AW), .DW(DW)) sdr_if ();

  layer_rom_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .CLK_32M  (CLK_32M),
    .reset    (reset),
    .req_en   (req_en),
    .req      (req),
    .req_addr (req_addr),
    .rdy      (rdy),
    .rdata    (rdata),
    .busy     (busy),
    .sdr      (sdr_if)
  );

  always #5 CLK_32M = ~CLK_32M;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdy"}, 64'(rdy), 64'h0);
    check({tag, " rdata"}, 64'(rdata[63:0]), 64'h0);
    check({tag, " rdata2"}, 64'(rdata[95:64]), 64'h0);
    check({tag, " sdr_req"}, 64'(sdr_if.sdr_req), 64'h0);
    check({tag, " sdr_addr"}, 64'(sdr_if.sdr_addr), 64'h0);
    check({tag, " busy"}, 64'(busy), 64'h0);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    req            = '0;
    req_en         = '1;
    sdr_if.sdr_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Polls for the next sdr_req with a bound; the caller's req pulse lasts one cycle.
  task automatic wait_sdr_req(input string tag, input logic [AW-1:0] exp_addr);
    int n;
    n = 0;
    tick();
    req = '0;
    while (!sdr_if.sdr_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, " sdr_req"}, 64'(sdr_if.sdr_req), 64'h1);
    check({tag, " sdr_addr"}, 64'(sdr_if.sdr_addr), 64'(exp_addr));
  endtask

  task automatic respond(input string tag, input int lat, input logic [DW-1:0] data,
                         input logic [NUM_REQ-1:0] exp_rdy, input logic [NUM_REQ-1:0] extra_req);
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) check({tag, " sdr_req pulse"}, 64'(sdr_if.sdr_req), 64'h0);
    end
    sdr_if.sdr_rdy  = 1'b1;
    sdr_if.sdr_data = data;
    req             = extra_req;
    tick();
    sdr_if.sdr_rdy  = 1'b0;
    sdr_if.sdr_data = '0;
    req             = '0;
    check({tag, " rdy"}, 64'(rdy), 64'(exp_rdy));
    check({tag, " busy"}, 64'(busy), 64'h0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_rdy[i]) check({tag, " rdata"}, 64'(rdata[i*DW +: DW]), 64'(data));
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int reqs;
    int rdys;
    reqs = 0;
    rdys = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sdr_if.sdr_req) reqs++;
      if (rdy != '0) rdys++;
    end
    check({tag, " no sdr_req"}, 64'(reqs), 64'h0);
    check({tag, " no rdy"}, 64'(rdys), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sdr_if.sdr_rdy  = 1'b0;
    sdr_if.sdr_data = '0;

    // Reset values, then exact single-request latency.
    tick();
    check_reset_outputs("reset");
    do_reset();
    set_addr(0, 21'h012340);
    req = 3'b001;
    tick();
    req = '0;
    check("lat c1 sdr_req", 64'(sdr_if.sdr_req), 64'h0);
    tick();
    check("lat c2 sdr_req", 64'(sdr_if.sdr_req), 64'h1);
    check("lat c2 sdr_addr", 64'(sdr_if.sdr_addr), 64'h012340);
    check("lat c2 busy", 64'(busy), 64'h1);
    tick();
    check("lat c3 sdr_req", 64'(sdr_if.sdr_req), 64'h0);
    check("lat c3 sdr_addr held", 64'(sdr_if.sdr_addr), 64'h012340);
    respond("lat c5", 2, 32'hDEADBEEF, 3'b001, 3'b000);
    tick();
    check("lat c7 rdy", 64'(rdy), 64'h0);

    // Round-robin bursts starting from requester 0.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      set_addr(0, 21'h100 + 21'(b));
      set_addr(1, 21'h200 + 21'(b));
      set_addr(2, 21'h300 + 21'(b));
      req = 3'b111;
      wait_sdr_req("rr g0", 21'h100 + 21'(b));
      respond("rr g0", 3, 32'hA000_0000 + 32'(b), 3'b001, 3'b000);
      wait_sdr_req("rr g1", 21'h200 + 21'(b));
      respond("rr g1", 3, 32'hA111_0000 + 32'(b), 3'b010, 3'b000);
      wait_sdr_req("rr g2", 21'h300 + 21'(b));
      respond("rr g2", 3, 32'hA222_0000 + 32'(b), 3'b100, 3'b000);
    end
    expect_quiet("rr idle", 6);

    // New request from the granted layer in the same cycle as sdr_rdy stays pending.
    do_reset();
    set_addr(0, 21'h0A0);
    set_addr(1, 21'h222);
    req = 3'b011;
    wait_sdr_req("same g0", 21'h0A0);
    respond("same g0", 3, 32'h1111_1111, 3'b001, 3'b000);
    wait_sdr_req("same g1", 21'h222);
    set_addr(1, 21'h555);
    respond("same g1 old", 3, 32'h2222_2222, 3'b010, 3'b010);
    wait_sdr_req("same g1 new", 21'h555);
    respond("same g1 new", 3, 32'h3333_3333, 3'b010, 3'b000);

    // Two requests from layer 2 while layer 0 is served: only the latest address goes out.
    set_addr(0, 21'h040);
    req = 3'b001;
    wait_sdr_req("ovw g0", 21'h040);
    set_addr(2, 21'h010);
    req = 3'b100;
    tick();
    set_addr(2, 21'h020);
    tick();
    req = '0;
    respond("ovw g0", 1, 32'h4444_4444, 3'b001, 3'b000);
    wait_sdr_req("ovw g2", 21'h020);
    respond("ovw g2", 3, 32'h5555_5555, 3'b100, 3'b000);
    expect_quiet("ovw once", 12);

    // Disabling a layer drops its pending slot and suppresses its rdy.
    do_reset();
    set_addr(0, 21'h111);
    set_addr(1, 21'h222);
    req = 3'b011;
    tick();
    req    = '0;
    req_en = 3'b101;
    wait_sdr_req("en g0", 21'h111);
    respond("en g0", 3, 32'h6666_6666, 3'b001, 3'b000);
    expect_quiet("en drop", 12);
    req_en = 3'b111;
    set_addr(1, 21'h333);
    req = 3'b010;
    wait_sdr_req("en wait", 21'h333);
    req_en = 3'b101;
    respond("en wait", 3, 32'h7777_7777, 3'b000, 3'b000);
    check("en wait rdata1", 64'(rdata[63:32]), 64'h0);
    req_en = 3'b111;
    expect_quiet("en wait idle", 6);

    // Reset during WAIT, then a stale sdr_rdy is ignored.
    set_addr(0, 21'h444);
    req = 3'b001;
    wait_sdr_req("rst wait", 21'h444);
    tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst async");
    tick();
    reset           = 1'b0;
    sdr_if.sdr_rdy  = 1'b1;
    sdr_if.sdr_data = 32'h8888_8888;
    tick();
    sdr_if.sdr_rdy  = 1'b0;
    sdr_if.sdr_data = '0;
    check_reset_outputs("rst stale");
    expect_quiet("rst stale", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
